// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between an instruction-fetch requester (I) and a
//   data requester (D). Commands pass through combinationally. D has priority,
//   but I is forced through after STARVE_LIMIT consecutive contended D grants.
//   A stalled grant is locked so the command stays stable until it is taken.
//   Read returns come back in order. A small tag FIFO records the owner of
//   each outstanding read and routes each return to that owner.
// Ports
//   Clock, Reset          : clock, synchronous active-high reset
//   IAddr/IRead           : fetch read request
//   IWaitreq/IReadValid/IReadData : fetch stall and return
//   DAddr/DRead/DWrite/DWriteData : data request (read+write => write)
//   DWaitreq/DReadValid/DReadData : data stall and return
//   MemAddr/MemRead/MemWrite/MemWriteData : shared memory command
//   MemWaitreq/MemReadValid/MemReadData   : memory stall and in-order return
//   ProtoErr              : sticky, set by a return with no outstanding read
module mem_port_arbiter #(
    parameter int WORD_SIZE    = 16,
    parameter int STARVE_LIMIT = 4,
    parameter int TAG_DEPTH    = 4
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [WORD_SIZE-1:0] IAddr,
    input  logic                 IRead,
    output logic                 IWaitreq,
    output logic                 IReadValid,
    output logic [WORD_SIZE-1:0] IReadData,
    input  logic [WORD_SIZE-1:0] DAddr,
    input  logic                 DRead,
    input  logic                 DWrite,
    input  logic [WORD_SIZE-1:0] DWriteData,
    output logic                 DWaitreq,
    output logic                 DReadValid,
    output logic [WORD_SIZE-1:0] DReadData,
    output logic [WORD_SIZE-1:0] MemAddr,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic [WORD_SIZE-1:0] MemWriteData,
    input  logic                 MemWaitreq,
    input  logic                 MemReadValid,
    input  logic [WORD_SIZE-1:0] MemReadData,
    output logic                 ProtoErr
);
    localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CW = $clog2(TAG_DEPTH + 1);

    logic [TAG_DEPTH-1:0] tag_q, tag_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 lock_q, lock_d, lock_own_q, lock_own_d;  // own: 1 = D
    logic [2:0]           starve_q, starve_d;
    logic                 perr_q, perr_d;

    logic full, empty, d_req, i_ok, d_ok, gnt_i, gnt_d;
    logic i_acc, d_acc, push, pop, head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(TAG_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (cnt_q == CW'(TAG_DEPTH));
    assign empty = (cnt_q == '0);
    assign d_req = DRead | DWrite;
    // Reads are only eligible while the FIFO has room for their tag.
    assign i_ok  = IRead & ~full;
    assign d_ok  = DWrite | (DRead & ~full);

    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        if (!Reset) begin
            if (lock_q && !lock_own_q && i_ok)      gnt_i = 1'b1;
            else if (lock_q && lock_own_q && d_ok)  gnt_d = 1'b1;
            else if (i_ok && d_ok) begin
                if (starve_q == 3'(STARVE_LIMIT))   gnt_i = 1'b1;
                else                                gnt_d = 1'b1;
            end
            else if (i_ok)                          gnt_i = 1'b1;
            else if (d_ok)                          gnt_d = 1'b1;
        end
    end

    always_comb begin
        MemAddr      = '0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        MemWriteData = '0;
        if (gnt_i) begin
            MemAddr = IAddr;
            MemRead = 1'b1;
        end else if (gnt_d) begin
            MemAddr      = DAddr;
            MemWrite     = DWrite;
            MemRead      = ~DWrite;
            MemWriteData = DWriteData;
        end
    end

    // A requesting loser (including a read blocked by a full FIFO) stalls.
    assign IWaitreq = Reset | (gnt_i ? MemWaitreq : IRead);
    assign DWaitreq = Reset | (gnt_d ? MemWaitreq : d_req);

    assign i_acc = gnt_i & ~MemWaitreq;
    assign d_acc = gnt_d & ~MemWaitreq;
    assign push  = i_acc | (d_acc & ~DWrite);
    assign pop   = MemReadValid & ~empty & ~Reset;
    assign head  = tag_q[rd_ptr_q];

    assign IReadValid = pop & ~head;
    assign DReadValid = pop & head;
    assign IReadData  = IReadValid ? MemReadData : '0;
    assign DReadData  = DReadValid ? MemReadData : '0;
    assign ProtoErr   = perr_q;

    always_comb begin
        tag_d    = tag_q;
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
        if (push) tag_d[wr_ptr_q] = gnt_d;
        // Lock holds while the granted port is stalled; dropping the request
        // or being accepted both leave it clear next cycle.
        lock_d     = (gnt_i | gnt_d) & MemWaitreq;
        lock_own_d = gnt_d;
        starve_d   = starve_q;
        if (i_acc)
            starve_d = '0;
        else if (d_acc && IRead && starve_q != 3'(STARVE_LIMIT))
            starve_d = starve_q + 3'd1;
        perr_d = perr_q | (MemReadValid & empty);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            tag_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            lock_q     <= 1'b0;
            lock_own_q <= 1'b0;
            starve_q   <= '0;
            perr_q     <= 1'b0;
        end else begin
            tag_q      <= tag_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            lock_q     <= lock_d;
            lock_own_q <= lock_own_d;
            starve_q   <= starve_d;
            perr_q     <= perr_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    logic        Clock = 1'b0, Reset = 1'b1;
    logic [15:0] IAddr, IReadData, DAddr, DWriteData, DReadData;
    logic [15:0] MemAddr, MemWriteData, MemReadData;
    logic        IRead, IWaitreq, IReadValid, DRead, DWrite, DWaitreq, DReadValid;
    logic        MemRead, MemWrite, MemWaitreq, MemReadValid, ProtoErr;
    int checks = 0, errors = 0;

    mem_port_arbiter #(.WORD_SIZE(16), .STARVE_LIMIT(4), .TAG_DEPTH(4)) dut (
        .Clock(Clock), .Reset(Reset),
        .IAddr(IAddr), .IRead(IRead), .IWaitreq(IWaitreq),
        .IReadValid(IReadValid), .IReadData(IReadData),
        .DAddr(DAddr), .DRead(DRead), .DWrite(DWrite), .DWriteData(DWriteData),
        .DWaitreq(DWaitreq), .DReadValid(DReadValid), .DReadData(DReadData),
        .MemAddr(MemAddr), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemWriteData(MemWriteData), .MemWaitreq(MemWaitreq),
        .MemReadValid(MemReadValid), .MemReadData(MemReadData),
        .ProtoErr(ProtoErr));

    always #5 Clock = ~Clock;

    typedef struct {
        logic rst, ir; logic [15:0] ia; logic dr, dw; logic [15:0] da, dd;
        logic mw, mv; logic [15:0] md;
        logic [15:0] ema; logic emr, emw; logic [15:0] emd;
        logic eiw, edw, eiv; logic [15:0] eid; logic edv; logic [15:0] edd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(logic rst, logic ir, logic [15:0] ia, logic dr, logic dw,
                               logic [15:0] da, logic [15:0] dd, logic mw, logic mv,
                               logic [15:0] md, logic [15:0] ema, logic emr, logic emw,
                               logic [15:0] emd, logic eiw, logic edw, logic eiv,
                               logic [15:0] eid, logic edv, logic [15:0] edd);
        vec_t r;
        r.rst = rst; r.ir = ir; r.ia = ia; r.dr = dr; r.dw = dw; r.da = da; r.dd = dd;
        r.mw = mw; r.mv = mv; r.md = md; r.ema = ema; r.emr = emr; r.emw = emw;
        r.emd = emd; r.eiw = eiw; r.edw = edw; r.eiv = eiv; r.eid = eid;
        r.edv = edv; r.edd = edd;
        return r;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic ir, input logic [15:0] ia,
                         input logic dr, input logic dw, input logic [15:0] da,
                         input logic [15:0] dd, input logic mw, input logic mv,
                         input logic [15:0] md);
        Reset = rst; IRead = ir; IAddr = ia; DRead = dr; DWrite = dw; DAddr = da;
        DWriteData = dd; MemWaitreq = mw; MemReadValid = mv; MemReadData = md;
    endtask

    task automatic next_cycle();
        @(posedge Clock); #1;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) next_cycle();

        //                rst ir ia       dr dw da       dd       mw mv md
        //                ema      emr emw emd      eiw edw eiv eid      edv edd
        vecs.push_back(v(1, 1, 16'h0010, 1, 0, 16'h0100, 0, 0, 0, 0,
                         0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        // single fetch, return next cycle
        vecs.push_back(v(0, 1, 16'h0010, 0, 0, 0, 0, 0, 0, 0,
                         16'h0010, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'hABCD,
                         0, 0, 0, 0, 0, 0, 1, 16'hABCD, 0, 0));
        // contention: D four times, then I, then D again
        for (int i = 0; i < 4; i++)
            vecs.push_back(v(0, 1, 16'h0020, 0, 1, 16'h0200, 16'h1234, 0, 0, 0,
                             16'h0200, 0, 1, 16'h1234, 1, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 16'h0020, 0, 1, 16'h0200, 16'h1234, 0, 0, 0,
                         16'h0020, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 16'h0020, 0, 1, 16'h0200, 16'h1234, 0, 0, 0,
                         16'h0200, 0, 1, 16'h1234, 1, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h5555,
                         0, 0, 0, 0, 0, 0, 1, 16'h5555, 0, 0));
        // fill FIFO with I,D,I,D
        vecs.push_back(v(0, 1, 16'h0030, 0, 0, 0, 0, 0, 0, 0,
                         16'h0030, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 16'h0300, 0, 0, 0, 0,
                         16'h0300, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 16'h0031, 0, 0, 0, 0, 0, 0, 0,
                         16'h0031, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 16'h0301, 0, 0, 0, 0,
                         16'h0301, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        // full: both reads blocked, writes still go (read+write counts as write)
        vecs.push_back(v(0, 1, 16'h0032, 1, 0, 16'h0302, 0, 0, 0, 0,
                         0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 16'h0032, 0, 1, 16'h0303, 16'hBEEF, 0, 0, 0,
                         16'h0303, 0, 1, 16'hBEEF, 1, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 16'h0032, 1, 1, 16'h0304, 16'h0F0F, 0, 0, 0,
                         16'h0304, 0, 1, 16'h0F0F, 1, 0, 0, 0, 0, 0));
        // in-order returns; pop+push together in the third
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h1111,
                         0, 0, 0, 0, 0, 0, 1, 16'h1111, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h2222,
                         0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h2222));
        vecs.push_back(v(0, 1, 16'h0040, 0, 0, 0, 0, 0, 1, 16'h3333,
                         16'h0040, 1, 0, 0, 0, 0, 1, 16'h3333, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h4444,
                         0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h4444));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h5555,
                         0, 0, 0, 0, 0, 0, 1, 16'h5555, 0, 0));

        foreach (vecs[n]) begin
            drive(vecs[n].rst, vecs[n].ir, vecs[n].ia, vecs[n].dr, vecs[n].dw,
                  vecs[n].da, vecs[n].dd, vecs[n].mw, vecs[n].mv, vecs[n].md);
            @(negedge Clock);
            chk($sformatf("v%0d MemAddr", n), MemAddr, vecs[n].ema);
            chk($sformatf("v%0d MemRead", n), 16'(MemRead), 16'(vecs[n].emr));
            chk($sformatf("v%0d MemWrite", n), 16'(MemWrite), 16'(vecs[n].emw));
            chk($sformatf("v%0d MemWriteData", n), MemWriteData, vecs[n].emd);
            chk($sformatf("v%0d IWaitreq", n), 16'(IWaitreq), 16'(vecs[n].eiw));
            chk($sformatf("v%0d DWaitreq", n), 16'(DWaitreq), 16'(vecs[n].edw));
            chk($sformatf("v%0d IReadValid", n), 16'(IReadValid), 16'(vecs[n].eiv));
            chk($sformatf("v%0d IReadData", n), IReadData, vecs[n].eid);
            chk($sformatf("v%0d DReadValid", n), 16'(DReadValid), 16'(vecs[n].edv));
            chk($sformatf("v%0d DReadData", n), DReadData, vecs[n].edd);
            next_cycle();
        end
        chk("ProtoErr after clean traffic", 16'(ProtoErr), 16'd0);

        // Lock: stalled D read keeps the grant while I arrives
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); next_cycle();
        drive(0, 0, 0, 1, 0, 16'h0500, 0, 1, 0, 0);
        @(negedge Clock);
        chk("lockD c0 MemAddr", MemAddr, 16'h0500);
        chk("lockD c0 DWaitreq", 16'(DWaitreq), 16'd1);
        next_cycle();
        for (int c = 1; c < 3; c++) begin
            drive(0, 1, 16'h0050, 1, 0, 16'h0500, 0, 1, 0, 0);
            @(negedge Clock);
            chk($sformatf("lockD c%0d MemAddr", c), MemAddr, 16'h0500);
            chk($sformatf("lockD c%0d IWaitreq", c), 16'(IWaitreq), 16'd1);
            chk($sformatf("lockD c%0d DWaitreq", c), 16'(DWaitreq), 16'd1);
            next_cycle();
        end
        drive(0, 1, 16'h0050, 1, 0, 16'h0500, 0, 0, 0, 0);
        @(negedge Clock);
        chk("lockD accept MemAddr", MemAddr, 16'h0500);
        chk("lockD accept DWaitreq", 16'(DWaitreq), 16'd0);
        chk("lockD accept IWaitreq", 16'(IWaitreq), 16'd1);
        next_cycle();
        drive(0, 1, 16'h0050, 0, 0, 0, 0, 0, 0, 0);
        @(negedge Clock);
        chk("after lockD I grant", MemAddr, 16'h0050);
        chk("after lockD IWaitreq", 16'(IWaitreq), 16'd0);
        next_cycle();
        // Lock on I overrides D priority
        drive(0, 1, 16'h0051, 0, 0, 0, 0, 1, 0, 0); next_cycle();
        drive(0, 1, 16'h0051, 0, 1, 16'h0600, 16'h7777, 1, 0, 0);
        @(negedge Clock);
        chk("lockI MemAddr", MemAddr, 16'h0051);
        chk("lockI MemWrite", 16'(MemWrite), 16'd0);
        chk("lockI DWaitreq", 16'(DWaitreq), 16'd1);
        next_cycle();

        // Full FIFO with a simultaneous return still refuses the new read
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); next_cycle();
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 16'(16'h0060 + k), 0, 0, 0, 0, 0, 0, 0); next_cycle();
        end
        drive(0, 1, 16'h0070, 0, 0, 0, 0, 0, 1, 16'h9999);
        @(negedge Clock);
        chk("full+pop MemRead", 16'(MemRead), 16'd0);
        chk("full+pop IWaitreq", 16'(IWaitreq), 16'd1);
        chk("full+pop IReadData", IReadData, 16'h9999);
        next_cycle();
        drive(0, 1, 16'h0070, 0, 0, 0, 0, 0, 0, 0);
        @(negedge Clock);
        chk("after pop MemRead", 16'(MemRead), 16'd1);
        chk("after pop IWaitreq", 16'(IWaitreq), 16'd0);
        next_cycle();

        // Spurious return
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h7777);
        @(negedge Clock);
        chk("spurious IReadValid", 16'(IReadValid), 16'd0);
        chk("spurious DReadValid", 16'(DReadValid), 16'd0);
        chk("spurious IReadData", IReadData, 16'd0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge Clock);
        chk("ProtoErr set", 16'(ProtoErr), 16'd1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge Clock);
        chk("ProtoErr sticky", 16'(ProtoErr), 16'd1);
        next_cycle();
        drive(1, 1, 16'h0080, 1, 0, 16'h0800, 0, 0, 1, 16'h4321);
        @(negedge Clock);
        chk("reset IWaitreq", 16'(IWaitreq), 16'd1);
        chk("reset DWaitreq", 16'(DWaitreq), 16'd1);
        chk("reset MemRead", 16'(MemRead), 16'd0);
        chk("reset IReadValid", 16'(IReadValid), 16'd0);
        chk("reset MemAddr", MemAddr, 16'd0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge Clock);
        chk("ProtoErr cleared", 16'(ProtoErr), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
